// File: rtl/prt_riscv_irq_ctl.sv
// N-channel interrupt front end: per-channel synchroniser, edge/level pending
// capture with overrun flags, masked lowest-index select and a single IRQ/ACK line.
module prt_riscv_irq_ctl #(
  parameter int P_CHANNELS    = 8,
  parameter int P_SYNC_STAGES = 2,
  parameter int P_ID_W        = $clog2(P_CHANNELS)
) (
  input  logic                  RST_IN,
  input  logic                  CLK_IN,
  input  logic [P_CHANNELS-1:0] IRQ_IN,
  input  logic [P_CHANNELS-1:0] MODE_IN,
  input  logic [P_CHANNELS-1:0] MASK_IN,
  input  logic                  ACK_IN,
  output logic                  IRQ_OUT,
  output logic [P_ID_W-1:0]     ID_OUT,
  output logic [P_CHANNELS-1:0] PEND_OUT,
  output logic [P_CHANNELS-1:0] OVR_OUT
);

  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

  state_t                  state_q, state_d;
  logic [P_ID_W-1:0]       id_q, id_d, win;
  logic [P_CHANNELS-1:0]   sync_q [P_SYNC_STAGES];
  logic [P_CHANNELS-1:0]   s, s_d, rise;
  logic [P_CHANNELS-1:0]   pend_q, pend_d, ovr_q, ovr_d;
  logic [P_CHANNELS-1:0]   act, ack_vec;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      for (int unsigned k = 0; k < P_SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= IRQ_IN;
      for (int unsigned k = 1; k < P_SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d <= s;
    end
  end

  assign s    = sync_q[P_SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign act  = pend_q & MASK_IN;

  // ACK only counts while a request is actually on the line
  always_comb begin
    ack_vec = '0;
    if (state_q == ASSERT && ACK_IN) ack_vec[id_q] = 1'b1;
  end

  // Edge channels: a new edge beats a same-cycle ACK; level channels follow s
  always_comb begin
    pend_d = (MODE_IN & (rise | (pend_q & ~ack_vec))) | (~MODE_IN & s);
    ovr_d  = (ovr_q & ~(ack_vec & MODE_IN)) | (rise & pend_q & MODE_IN);
  end

  always_comb begin
    win = '0;
    for (int unsigned i = P_CHANNELS; i > 0; i--) begin
      if (act[i-1]) win = P_ID_W'(i-1);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (|act) begin
          state_d = ASSERT;
          id_d    = win;
        end
      end
      ASSERT: begin
        if (ACK_IN || !act[id_q]) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q <= IDLE;
      id_q    <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign IRQ_OUT  = (state_q == ASSERT);
  assign ID_OUT   = id_q;
  assign PEND_OUT = pend_q;
  assign OVR_OUT  = ovr_q;

endmodule
